seg7_scan_decoder: RTL and testbench

//   Reader for the multiplexed seven-segment bus (seg/anode) driven by the counter display path.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/seg7_scan_decoder.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, scan FSM states and anode helper for the seven-segment bus reader
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // index of the lowest zero bit; only meaningful when exactly one bit is low
    function automatic logic [2:0] onehot_low_index(input logic [7:0] a);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!a[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-high 7-segment pattern to {valid, blank, nibble}
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] nibble
);

    // table lookup; unknown and blank patterns yield nibble 0 with valid low
    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
        blank = pattern == SEG_BLANK;
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reconstructs per-digit hex values from a scanned seg/anode bus; SEG7_DP_EN adds decimal points
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   anode,
`ifdef SEG7_DP_EN
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_lit,
    output logic                    frame_valid,
    output logic                    code_err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef SEG7_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif

    logic [6:0]              seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0]   anode_s1, anode_s2, lows, sel;
    logic [SW-1:0]           cur, prev;
    logic [7:0]              anode_pad;
    logic [2:0]              idx;
    logic                    one_low, capture, publish;
    logic                    pat_valid, pat_blank;
    logic [3:0]              pat_nibble;
    logic [CW-1:0]           cnt, cnt_d;
    state_t                  state, state_d;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_lit, seen;
`ifdef SEG7_DP_EN
    logic                    dp_s1, dp_s2;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    assign cur = {dp_s2, anode_s2, seg_s2};
`else
    assign cur = {anode_s2, seg_s2};
`endif

    assign lows    = ~anode_s2;
    assign one_low = (lows != '0) && ((lows & (lows - 1'b1)) == '0);
    assign idx     = onehot_low_index(anode_pad);

    seg7_pattern_decode u_dec (
        .pattern (~seg_s2),
        .valid   (pat_valid),
        .blank   (pat_blank),
        .nibble  (pat_nibble)
    );

    // widen the anode word to the helper's 8-bit view and one-hot the selected digit
    always_comb begin
        anode_pad = '1;
        anode_pad[NUM_DIGITS-1:0] = anode_s2;
        for (int i = 0; i < NUM_DIGITS; i++)
            sel[i] = idx == 3'(i);
    end

    // two-flop synchronizers plus the previous-sample register used for stability
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1   <= '1;
            seg_s2   <= '1;
            anode_s1 <= '1;
            anode_s2 <= '1;
`ifdef SEG7_DP_EN
            dp_s1    <= 1'b1;
            dp_s2    <= 1'b1;
`endif
            prev     <= '1;
        end else begin
            seg_s1   <= seg;
            seg_s2   <= seg_s1;
            anode_s1 <= anode;
            anode_s2 <= anode_s1;
`ifdef SEG7_DP_EN
            dp_s1    <= dp;
            dp_s2    <= dp_s1;
`endif
            prev     <= cur;
        end
    end

    // state and stability counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // scan FSM: an invalid anode word always aborts; captures fire on the last settled sample
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        if (!one_low) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = SETTLE;
                    cnt_d   = CW'(1);
                end
                SETTLE: begin
                    if (cur != prev) begin
                        cnt_d = CW'(1);
                    end else if (cnt == CNT_LAST) begin
                        capture = 1'b1;
                        state_d = HOLD;
                        cnt_d   = CW'(SETTLE_CYCLES);
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (cur != prev) begin
                        state_d = SETTLE;
                        cnt_d   = CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // shadow capture, seen tracking, and frame publish one edge after the completing capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            shadow_lit  <= '0;
            seen        <= '0;
            publish     <= 1'b0;
            value       <= '0;
            digit_lit   <= '0;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
`ifdef SEG7_DP_EN
            shadow_dp   <= '0;
            dp_out      <= '0;
`endif
        end else begin
            frame_valid <= publish;
            publish     <= capture && ((seen | sel) == '1);
            seen        <= publish ? '0 : capture ? (seen | sel) : seen;
            if (publish) begin
                value     <= shadow;
                digit_lit <= shadow_lit;
`ifdef SEG7_DP_EN
                dp_out    <= shadow_dp;
`endif
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel[i]) begin
                    shadow[4*i +: 4] <= pat_nibble;
                    shadow_lit[i]    <= pat_valid;
`ifdef SEG7_DP_EN
                    shadow_dp[i]     <= ~dp_s2;
`endif
                end
            end
            if (capture && !pat_valid && !pat_blank)
                code_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed checks of the seven-segment scan reader; SEG7_DP_EN enables the dp scenario
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg = '1;
    logic [7:0]  anode = '1;
    logic [31:0] value;
    logic [7:0]  digit_lit;
    logic        frame_valid;
    logic        code_err;
`ifdef SEG7_DP_EN
    logic        dp = 1'b1;
    logic [7:0]  dp_out;
    logic [7:0]  fv_dp = '0;
`endif

    int          errors = 0;
    int          checks = 0;
    int          fv_count = 0;
    logic [31:0] fv_value = '0;
    logic [7:0]  fv_lit = '0;

    seg7_scan_decoder #(.NUM_DIGITS(8), .SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .anode       (anode),
`ifdef SEG7_DP_EN
        .dp          (dp),
        .dp_out      (dp_out),
`endif
        .value       (value),
        .digit_lit   (digit_lit),
        .frame_valid (frame_valid),
        .code_err    (code_err)
    );

    always #5 clk = ~clk;

    // record every published frame shortly after the edge that raised frame_valid
    always @(posedge clk) begin
        #2;
        if (frame_valid) begin
            fv_count++;
            fv_value = value;
            fv_lit   = digit_lit;
`ifdef SEG7_DP_EN
            fv_dp    = dp_out;
`endif
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic show(input int d, input logic [6:0] pat, input int cyc);
        anode = ~(8'h01 << d);
        seg   = ~pat;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic idle(input int cyc);
        anode = '1;
        seg   = '1;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan_range(input logic [31:0] v, input int lo, input int hi);
        for (int d = lo; d <= hi; d++) show(d, seg_of(v[4*d +: 4]), 6);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected %h", value, 32'h0); end
        checks++; if (digit_lit !== 8'h00) begin errors++; $display("FAIL reset_lit: got %h expected %h", digit_lit, 8'h00); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL reset_code_err: got %b expected 0", code_err); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan;
        int n0;
        n0 = fv_count;
        scan_range(32'h87654321, 0, 7);
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL full_scan_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_value !== 32'h87654321) begin errors++; $display("FAIL full_scan_value: got %h expected %h", fv_value, 32'h87654321); end
        checks++; if (fv_lit !== 8'hFF) begin errors++; $display("FAIL full_scan_lit: got %h expected %h", fv_lit, 8'hFF); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL full_scan_code_err: got %b expected 0", code_err); end
    endtask

    task automatic test_settle_restart;
        int n0;
        n0 = fv_count;
        for (int d = 0; d < 8; d++) begin
            if (d == 3) begin
                show(3, 7'h77, 3);
                show(3, 7'h71, 6);
            end else begin
                show(d, seg_of(4'(d)), 6);
            end
        end
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL settle_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_value !== 32'h7654F210) begin errors++; $display("FAIL settle_value: got %h expected %h", fv_value, 32'h7654F210); end
    endtask

    task automatic test_invalid_anode;
        int n0;
        n0 = fv_count;
        scan_range(32'h0FEDCBA9, 0, 3);
        anode = 8'hFC;
        seg   = ~seg_of(4'h5);
        repeat (20) @(negedge clk);
        checks++; if (fv_count !== n0) begin errors++; $display("FAIL invalid_anode_no_frame: got %0d expected %0d", fv_count - n0, 0); end
        scan_range(32'h0FEDCBA9, 4, 7);
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL invalid_anode_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_value !== 32'h0FEDCBA9) begin errors++; $display("FAIL invalid_anode_value: got %h expected %h", fv_value, 32'h0FEDCBA9); end
        checks++; if (fv_lit !== 8'hFF) begin errors++; $display("FAIL invalid_anode_lit: got %h expected %h", fv_lit, 8'hFF); end
    endtask

    task automatic test_blank_unknown;
        for (int d = 0; d < 8; d++) show(d, (d == 5) ? 7'h00 : seg_of(4'(d + 1)), 6);
        idle(6);
        checks++; if (fv_value !== 32'h87054321) begin errors++; $display("FAIL blank_value: got %h expected %h", fv_value, 32'h87054321); end
        checks++; if (fv_lit !== 8'hDF) begin errors++; $display("FAIL blank_lit: got %h expected %h", fv_lit, 8'hDF); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL blank_code_err: got %b expected 0", code_err); end
        for (int d = 0; d < 8; d++) show(d, (d == 2) ? 7'h01 : seg_of(4'(d + 1)), 6);
        idle(6);
        checks++; if (fv_value !== 32'h87654021) begin errors++; $display("FAIL unknown_value: got %h expected %h", fv_value, 32'h87654021); end
        checks++; if (fv_lit !== 8'hFB) begin errors++; $display("FAIL unknown_lit: got %h expected %h", fv_lit, 8'hFB); end
        checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL unknown_code_err: got %b expected 1", code_err); end
        scan_range(32'h87654321, 0, 7);
        idle(6);
        checks++; if (fv_value !== 32'h87654321) begin errors++; $display("FAIL clean_after_err_value: got %h expected %h", fv_value, 32'h87654321); end
        checks++; if (fv_lit !== 8'hFF) begin errors++; $display("FAIL clean_after_err_lit: got %h expected %h", fv_lit, 8'hFF); end
        checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL sticky_code_err: got %b expected 1", code_err); end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = fv_count;
        scan_range(32'h01234567, 0, 6);
        show(7, seg_of(4'hE), 3);
        idle(8);
        checks++; if (fv_count !== n0) begin errors++; $display("FAIL glitch_no_frame: got %0d expected %0d", fv_count - n0, 0); end
        show(7, seg_of(4'h9), 4);
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL min_settle_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_value !== 32'h91234567) begin errors++; $display("FAIL min_settle_value: got %h expected %h", fv_value, 32'h91234567); end
    endtask

    task automatic test_reset_mid;
        int n0;
        scan_range(32'hCCCCCCCC, 0, 3);
        show(4, seg_of(4'h1), 2);
        rst = 1'b0;
        #1;
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL mid_reset_value: got %h expected %h", value, 32'h0); end
        checks++; if (digit_lit !== 8'h00) begin errors++; $display("FAIL mid_reset_lit: got %h expected %h", digit_lit, 8'h00); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL mid_reset_code_err: got %b expected 0", code_err); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_fv: got %b expected 0", frame_valid); end
        idle(3);
        rst = 1'b1;
        n0 = fv_count;
        scan_range(32'h43218765, 4, 7);
        idle(6);
        checks++; if (fv_count !== n0) begin errors++; $display("FAIL mid_reset_seen_cleared: got %0d expected %0d", fv_count - n0, 0); end
        scan_range(32'h43218765, 0, 3);
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL post_reset_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_value !== 32'h43218765) begin errors++; $display("FAIL post_reset_value: got %h expected %h", fv_value, 32'h43218765); end
    endtask

`ifdef SEG7_DP_EN
    task automatic test_dp;
        int n0;
        n0 = fv_count;
        for (int d = 0; d < 8; d++) begin
            dp = (d == 0) ? 1'b0 : 1'b1;
            show(d, seg_of(4'(d + 1)), 6);
        end
        dp = 1'b1;
        idle(6);
        checks++; if (fv_count !== n0 + 1) begin errors++; $display("FAIL dp_frames: got %0d expected %0d", fv_count - n0, 1); end
        checks++; if (fv_dp !== 8'h01) begin errors++; $display("FAIL dp_out: got %h expected %h", fv_dp, 8'h01); end
        checks++; if (fv_value !== 32'h87654321) begin errors++; $display("FAIL dp_value: got %h expected %h", fv_value, 32'h87654321); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset;
        test_full_scan;
        test_settle_restart;
        test_invalid_anode;
        test_blank_unknown;
        test_glitch;
        test_reset_mid;
`ifdef SEG7_DP_EN
        test_dp;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
